// File: rtl/ptp_piezo_scheduler.sv
// ptp_piezo_scheduler
//   Per-channel piezo pulse scheduler driven by a PTP local time base.
//   Each channel is armed with a trigger time and a pulse width. It fires
//   when the local time reaches the trigger time, and the compare is safe
//   across time wrap.
//   Optional feature: define PIEZO_SCHED_CAPTURE_EN to timestamp rising
//   edges of the asynchronous event_trigger inputs into cap_time/cap_valid.
module ptp_piezo_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int TIME_W  = 32,
  parameter int PULSE_W = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TIME_W-1:0]        time_in,
  input  logic                     cfg_wr,
  input  logic                     cfg_abort,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [TIME_W-1:0]        cfg_time,
  input  logic [PULSE_W-1:0]       cfg_width,
  input  logic [NUM_CH-1:0]        event_trigger,
  output logic [NUM_CH-1:0]        piezo_out,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        done,
  output logic                     cfg_err,
  output logic [NUM_CH*TIME_W-1:0] cap_time,
  output logic [NUM_CH-1:0]        cap_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2
  } ch_state_t;

  // Command addresses an existing channel
  logic              ch_ok;
  // Per-channel: arm command rejected because the channel is mid-pulse
  logic [NUM_CH-1:0] arm_rej;
  // Per-channel: arm command addressed to this channel (clears capture flag)
  logic [NUM_CH-1:0] arm_hit;
  logic              cfg_err_reg;
  logic              cfg_err_next;

  assign ch_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t          state_reg, state_next;
      logic [TIME_W-1:0]  trig_reg, trig_next;
      logic [PULSE_W-1:0] width_reg, width_next;
      logic [PULSE_W-1:0] cnt_reg, cnt_next;
      logic               piezo_reg, piezo_next;
      logic               busy_reg, busy_next;
      logic               done_reg, done_next;
      logic               sel;
      logic               elapsed_msb;
      logic [TIME_W-2:0]  unused_elapsed_lsbs;
      logic               due;

      assign sel = cfg_wr && ch_ok && (cfg_ch == CH_W'(gi));

      // Wrap-safe "time has reached trigger": modular difference is non-negative
      assign {elapsed_msb, unused_elapsed_lsbs} = time_in - trig_reg;
      assign due = ~elapsed_msb;

      assign arm_rej[gi] = sel && !cfg_abort && (state_reg == ST_PULSE);
      assign arm_hit[gi] = sel && !cfg_abort;

      // Channel state and registered outputs
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg <= ST_IDLE;
          trig_reg  <= '0;
          width_reg <= '0;
          cnt_reg   <= '0;
          piezo_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          trig_reg  <= trig_next;
          width_reg <= width_next;
          cnt_reg   <= cnt_next;
          piezo_reg <= piezo_next;
          busy_reg  <= busy_next;
          done_reg  <= done_next;
        end
      end

      // Next-state logic: arm/re-arm/abort handling, trigger compare, pulse count
      always_comb begin
        state_next = state_reg;
        trig_next  = trig_reg;
        width_next = width_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (sel && !cfg_abort) begin
              state_next = ST_ARMED;
              trig_next  = cfg_time;
              width_next = cfg_width;
            end
          end
          ST_ARMED: begin
            if (sel && cfg_abort) begin
              state_next = ST_IDLE;
            end else if (sel) begin
              // Re-arm wins over a compare hit on the old time
              trig_next  = cfg_time;
              width_next = cfg_width;
            end else if (due) begin
              state_next = ST_PULSE;
              cnt_next   = (width_reg == '0) ? PULSE_W'(1) : width_reg;
            end
          end
          ST_PULSE: begin
            if (sel && cfg_abort) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else if (cnt_reg <= PULSE_W'(1)) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
              done_next  = 1'b1;
            end else begin
              cnt_next = cnt_reg - PULSE_W'(1);
            end
          end
          default: begin
            state_next = ST_IDLE;
          end
        endcase
        piezo_next = (state_next == ST_PULSE);
        busy_next  = (state_next != ST_IDLE);
      end

      assign piezo_out[gi] = piezo_reg;
      assign ch_busy[gi]   = busy_reg;
      assign done[gi]      = done_reg;
    end
  endgenerate

  assign cfg_err_next = cfg_err_reg | (|arm_rej) | (cfg_wr & ~ch_ok);

  // Sticky command-error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_err_next;
    end
  end

  assign cfg_err = cfg_err_reg;

`ifdef PIEZO_SCHED_CAPTURE_EN
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_cap
      logic              sync1_reg;
      logic              sync2_reg;
      logic              prev_reg;
      logic              rise_reg;
      logic [TIME_W-1:0] cap_time_reg;
      logic              cap_valid_reg;

      // Two-flop synchroniser, registered rising-edge detect, then timestamp
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg     <= 1'b0;
          sync2_reg     <= 1'b0;
          prev_reg      <= 1'b0;
          rise_reg      <= 1'b0;
          cap_time_reg  <= '0;
          cap_valid_reg <= 1'b0;
        end else begin
          sync1_reg <= event_trigger[gi];
          sync2_reg <= sync1_reg;
          prev_reg  <= sync2_reg;
          rise_reg  <= sync2_reg & ~prev_reg;
          if (rise_reg) begin
            cap_time_reg  <= time_in;
            cap_valid_reg <= 1'b1;
          end else if (arm_hit[gi]) begin
            cap_valid_reg <= 1'b0;
          end
        end
      end

      assign cap_time[gi*TIME_W +: TIME_W] = cap_time_reg;
      assign cap_valid[gi]                 = cap_valid_reg;
    end
  endgenerate
`else
  // Capture disabled: event inputs are ignored
  logic unused_capture;
  assign unused_capture = ^{event_trigger, arm_hit};
  assign cap_time  = '0;
  assign cap_valid = '0;
`endif

endmodule

// File: tb/tb_ptp_piezo_scheduler.sv
// Testbench for ptp_piezo_scheduler: directed scenarios with literal
// expectations plus randomized commands, checked every cycle against a
// behavioural channel model.
`timescale 1ns/1ps
module tb_ptp_piezo_scheduler;
  localparam int NUM_CH  = 5;
  localparam int TIME_W  = 32;
  localparam int PULSE_W = 16;
  localparam int CH_W    = 3;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [TIME_W-1:0]        time_in = '0;
  logic                     cfg_wr = 1'b0;
  logic                     cfg_abort = 1'b0;
  logic [CH_W-1:0]          cfg_ch = '0;
  logic [TIME_W-1:0]        cfg_time = '0;
  logic [PULSE_W-1:0]       cfg_width = '0;
  logic [NUM_CH-1:0]        event_trigger = '0;
  logic [NUM_CH-1:0]        piezo_out;
  logic [NUM_CH-1:0]        ch_busy;
  logic [NUM_CH-1:0]        done;
  logic                     cfg_err;
  logic [NUM_CH*TIME_W-1:0] cap_time;
  logic [NUM_CH-1:0]        cap_valid;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  bit          m_armed [NUM_CH];
  logic [31:0] m_trig  [NUM_CH];
  int          m_wid   [NUM_CH];
  int          m_left  [NUM_CH];   // remaining high cycles of the current pulse
  bit          m_done  [NUM_CH];
  bit          m_err;
  logic [31:0] m_cap   [NUM_CH];
  bit          m_capv  [NUM_CH];
`ifdef PIEZO_SCHED_CAPTURE_EN
  logic [NUM_CH-1:0] evh [5];      // event samples, evh[k] = k posedges ago
`endif

  // Directed-scenario trackers sampled at negedge
  logic [31:0] first_hi [NUM_CH];
  int          hi_cnt   [NUM_CH];
  int          done_cnt [NUM_CH];

  ptp_piezo_scheduler #(
    .NUM_CH (NUM_CH),
    .TIME_W (TIME_W),
    .PULSE_W(PULSE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .time_in      (time_in),
    .cfg_wr       (cfg_wr),
    .cfg_abort    (cfg_abort),
    .cfg_ch       (cfg_ch),
    .cfg_time     (cfg_time),
    .cfg_width    (cfg_width),
    .event_trigger(event_trigger),
    .piezo_out    (piezo_out),
    .ch_busy      (ch_busy),
    .done         (done),
    .cfg_err      (cfg_err),
    .cap_time     (cap_time),
    .cap_valid    (cap_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Model update for one rising edge, from the rules of the channel behaviour
  task automatic model_step();
    int el;
    bit sel;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_armed[c] = 0; m_trig[c] = '0; m_wid[c] = 0; m_left[c] = 0;
        m_done[c] = 0; m_cap[c] = '0; m_capv[c] = 0;
      end
      m_err = 0;
`ifdef PIEZO_SCHED_CAPTURE_EN
      for (int k = 0; k < 5; k++) evh[k] = '0;
`endif
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      sel = cfg_wr && (int'(cfg_ch) == c);
      m_done[c] = 0;
      if (m_left[c] > 0) begin
        if (sel && cfg_abort) begin
          m_left[c] = 0;
        end else begin
          if (sel) m_err = 1;
          m_left[c]--;
          if (m_left[c] == 0) m_done[c] = 1;
        end
      end else if (m_armed[c]) begin
        if (sel && cfg_abort) begin
          m_armed[c] = 0;
        end else if (sel) begin
          m_trig[c] = cfg_time;
          m_wid[c]  = int'(cfg_width);
        end else begin
          el = int'(time_in - m_trig[c]);
          if (el >= 0) begin
            m_armed[c] = 0;
            m_left[c]  = (m_wid[c] == 0) ? 1 : m_wid[c];
          end
        end
      end else if (sel && !cfg_abort) begin
        m_armed[c] = 1;
        m_trig[c]  = cfg_time;
        m_wid[c]   = int'(cfg_width);
      end
    end
    if (cfg_wr && int'(cfg_ch) >= NUM_CH) m_err = 1;
`ifdef PIEZO_SCHED_CAPTURE_EN
    for (int k = 4; k > 0; k--) evh[k] = evh[k-1];
    evh[0] = event_trigger;
    for (int c = 0; c < NUM_CH; c++) begin
      if (evh[3][c] && !evh[4][c]) begin
        m_cap[c]  = time_in;
        m_capv[c] = 1;
      end else if (cfg_wr && !cfg_abort && int'(cfg_ch) == c) begin
        m_capv[c] = 0;
      end
    end
`endif
  endtask

  // Model advance and per-cycle comparison, 1 ns after each rising edge
  always @(posedge clk) begin
    model_step();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("piezo_out[%0d]", c), 64'(piezo_out[c]), 64'(m_left[c] > 0));
      chk($sformatf("ch_busy[%0d]", c), 64'(ch_busy[c]), 64'(m_armed[c] || m_left[c] > 0));
      chk($sformatf("done[%0d]", c), 64'(done[c]), 64'(m_done[c]));
      chk($sformatf("cap_valid[%0d]", c), 64'(cap_valid[c]), 64'(m_capv[c]));
      chk($sformatf("cap_time[%0d]", c), 64'(cap_time[c*TIME_W +: TIME_W]), 64'(m_cap[c]));
    end
    chk("cfg_err", 64'(cfg_err), 64'(m_err));
  end

  task automatic clr_trk();
    for (int c = 0; c < NUM_CH; c++) begin
      first_hi[c] = '0; hi_cnt[c] = 0; done_cnt[c] = 0;
    end
  endtask

  task automatic sample_trk();
    for (int c = 0; c < NUM_CH; c++) begin
      if (piezo_out[c]) begin
        if (hi_cnt[c] == 0) first_hi[c] = time_in;
        hi_cnt[c]++;
      end
      if (done[c]) done_cnt[c]++;
    end
  endtask

  // One cycle: sample trackers, advance time by one, drive a command (or none)
  task automatic tick(input bit wr, input bit ab, input int ch, input logic [31:0] t, input int w);
    @(negedge clk);
    sample_trk();
    time_in   = time_in + 1;
    cfg_wr    = wr;
    cfg_abort = ab;
    cfg_ch    = CH_W'(ch);
    cfg_time  = t;
    cfg_width = PULSE_W'(w);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, '0, 0);
  endtask

  task automatic jump(input logic [31:0] v);
    @(negedge clk);
    sample_trk();
    time_in   = v;
    cfg_wr    = 1'b0;
    cfg_abort = 1'b0;
  endtask

  initial begin
    int r;
    int ch;
    logic [31:0] t;
    clr_trk();
    repeat (3) @(negedge clk);
    chk("reset_piezo", 64'(piezo_out), 64'(0));
    chk("reset_busy", 64'(ch_busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_err", 64'(cfg_err), 64'(0));
    chk("reset_capv", 64'(cap_valid), 64'(0));
    chk("reset_capt", 64'(cap_time), 64'(0));
    reset = 1'b0;

    // Basic pulse: trigger 100, width 5
    clr_trk();
    jump(90);
    tick(1, 0, 0, 32'd100, 5);
    idle(20);
    chk("basic_first", 64'(first_hi[0]), 64'd100);
    chk("basic_len", 64'(hi_cnt[0]), 64'd5);
    chk("basic_done", 64'(done_cnt[0]), 64'd1);

    // Trigger across time wrap
    clr_trk();
    jump(32'hFFFF_FFF0);
    tick(1, 0, 1, 32'h0000_0004, 3);
    idle(30);
    chk("wrap_first", 64'(first_hi[1]), 64'd4);
    chk("wrap_len", 64'(hi_cnt[1]), 64'd3);
    chk("wrap_done", 64'(done_cnt[1]), 64'd1);

    // Re-arm from 50 to 80 before the first trigger
    clr_trk();
    jump(30);
    tick(1, 0, 2, 32'd50, 2);
    idle(8);
    tick(1, 0, 2, 32'd80, 2);
    idle(50);
    chk("rearm_first", 64'(first_hi[2]), 64'd80);
    chk("rearm_len", 64'(hi_cnt[2]), 64'd2);
    chk("rearm_done", 64'(done_cnt[2]), 64'd1);

    // Trigger already in the past fires on the first armed cycle
    clr_trk();
    jump(600);
    tick(1, 0, 2, 32'd590, 2);
    idle(6);
    chk("past_first", 64'(first_hi[2]), 64'd602);
    chk("no_err_yet", 64'(cfg_err), 64'd0);

    // Arm during pulse is rejected, pulse length unchanged
    clr_trk();
    jump(200);
    tick(1, 0, 3, 32'd203, 6);
    idle(3);
    tick(1, 0, 3, 32'd900, 2);
    idle(10);
    chk("inpulse_err", 64'(cfg_err), 64'd1);
    chk("inpulse_first", 64'(first_hi[3]), 64'd203);
    chk("inpulse_len", 64'(hi_cnt[3]), 64'd6);
    chk("inpulse_done", 64'(done_cnt[3]), 64'd1);

    // Abort mid-pulse: low next cycle, no done
    clr_trk();
    jump(300);
    tick(1, 0, 3, 32'd302, 8);
    idle(3);
    tick(1, 1, 3, '0, 0);
    idle(10);
    chk("abort_len", 64'(hi_cnt[3]), 64'd3);
    chk("abort_done", 64'(done_cnt[3]), 64'd0);
    chk("abort_busy", 64'(ch_busy[3]), 64'd0);

    // Width 0 behaves as width 1
    clr_trk();
    jump(400);
    tick(1, 0, 4, 32'd402, 0);
    idle(6);
    chk("w0_first", 64'(first_hi[4]), 64'd402);
    chk("w0_len", 64'(hi_cnt[4]), 64'd1);
    chk("w0_done", 64'(done_cnt[4]), 64'd1);

    // Reset asserted mid-pulse drops everything immediately
    clr_trk();
    jump(500);
    tick(1, 0, 0, 32'd502, 10);
    idle(4);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_piezo", 64'(piezo_out), 64'd0);
    chk("rstmid_busy", 64'(ch_busy), 64'd0);
    chk("rstmid_err", 64'(cfg_err), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    clr_trk();
    idle(15);
    chk("rstmid_nodone", 64'(done_cnt[0]), 64'd0);
    chk("rstmid_nohi", 64'(hi_cnt[0]), 64'd0);

    // Out-of-range channel: error, no channel affected
    tick(1, 0, NUM_CH, 32'd0, 3);
    idle(3);
    chk("badch_err", 64'(cfg_err), 64'd1);
    chk("badch_busy", 64'(ch_busy), 64'd0);

    // Event capture on channel 1 while time_in = 200
    jump(200);
    event_trigger = 5'b00010;
    idle(6);
`ifdef PIEZO_SCHED_CAPTURE_EN
    chk("cap_time1", 64'(cap_time[1*TIME_W +: TIME_W]), 64'd203);
    chk("cap_valid1", 64'(cap_valid[1]), 64'd1);
`else
    chk("cap_time_off", 64'(cap_time[1*TIME_W +: TIME_W]), 64'd0);
    chk("cap_valid_off", 64'(cap_valid), 64'd0);
`endif
    tick(1, 0, 1, time_in + 1000, 1);
    idle(1);
    chk("cap_clear1", 64'(cap_valid[1]), 64'd0);
    tick(1, 1, 1, '0, 0);
    event_trigger = '0;
    idle(4);

    // Randomized commands, events, time jumps and occasional resets
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 999);
      if (r < 150) begin
        ch = $urandom_range(0, NUM_CH);
        t  = time_in + 32'($urandom_range(0, 60)) - 32'd10;
        tick(1, ($urandom_range(0, 3) == 0), ch, t, $urandom_range(0, 6));
      end else if (r < 155) begin
        jump(time_in + $urandom);
      end else if (r < 158) begin
        @(negedge clk);
        reset = 1'b1;
        cfg_wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        idle(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 9) == 0) event_trigger[c] = ~event_trigger[c];
      end
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
